// File: rtl/bist_sig_checker.sv
// BIST signature checker: replays a 4-bit golden MISR alongside BIST_TOP and
// compares each qualified signature, tallying matches, mismatches and the first failing index.
module bist_sig_checker #(
  parameter int unsigned NUM_TESTS = 255,
  parameter int unsigned SETTLE    = 2,
  parameter logic [3:0]  SEED      = 4'b0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       sig_valid,
  input  logic [7:0] result_in,
  input  logic [3:0] sig_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count,
  output logic       fail_seen,
  output logic [7:0] first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] LAST_IDX    = 8'(NUM_TESTS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] golden_q, golden_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] pass_count_q, pass_count_d;
  logic [7:0] fail_count_q, fail_count_d;
  logic [7:0] first_fail_idx_q, first_fail_idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_seen_q, fail_seen_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] golden_step(input logic [3:0] g, input logic [7:0] r);
    return {g[2:0], g[3] ^ g[2]} ^ (r[7:4] ^ r[3:0]);
  endfunction

  always_comb begin
    state_d          = state_q;
    golden_d         = golden_q;
    settle_cnt_d     = settle_cnt_q;
    idx_d            = idx_q;
    pass_count_d     = pass_count_q;
    fail_count_d     = fail_count_q;
    first_fail_idx_d = first_fail_idx_q;
    done_d           = done_q;
    pass_d           = pass_q;
    fail_seen_d      = fail_seen_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = (SETTLE == 0) ? S_RUN : S_SETTLE;
          golden_d         = SEED;
          settle_cnt_d     = 4'd0;
          idx_d            = 8'd0;
          pass_count_d     = 8'd0;
          fail_count_d     = 8'd0;
          first_fail_idx_d = 8'd0;
          fail_seen_d      = 1'b0;
          done_d           = 1'b0;
          pass_d           = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        // abort discards the beat presented with it, including the terminal one
        if (abort) begin
          state_d = S_IDLE;
        end else if (sig_valid) begin
          if (sig_in == golden_q) begin
            pass_count_d = sat_inc(pass_count_q);
          end else begin
            fail_count_d = sat_inc(fail_count_q);
            if (!fail_seen_q) begin
              first_fail_idx_d = idx_q;
              fail_seen_d      = 1'b1;
            end
          end
          golden_d = golden_step(golden_q, result_in);
          idx_d    = idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (fail_count_d == 8'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      golden_q         <= SEED;
      settle_cnt_q     <= 4'd0;
      idx_q            <= 8'd0;
      pass_count_q     <= 8'd0;
      fail_count_q     <= 8'd0;
      first_fail_idx_q <= 8'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_seen_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      golden_q         <= golden_d;
      settle_cnt_q     <= settle_cnt_d;
      idx_q            <= idx_d;
      pass_count_q     <= pass_count_d;
      fail_count_q     <= fail_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      fail_seen_q      <= fail_seen_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign pass_count     = pass_count_q;
  assign fail_count     = fail_count_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_idx = first_fail_idx_q;

endmodule
